fetch_sequencer: RTL and testbench

//   Owns the program counter and sequences the combinational instruction ROM
//   (byte address in, 32-bit word out, same cycle). Each cycle it issues one

---
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter and drives the combinational
// instruction ROM. Each cycle it issues one fetch into the IF/ID register,
// applies hazard freeze and branch redirect there, and lends the single ROM
// read port to a debug/loader requester through a req/ack handshake.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       PC_STEP      = 4,
    parameter int unsigned       DBG_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_adrs,
    input  logic [31:0]       imem_inst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_adrs,
    output logic              dbg_ack,
    output logic [31:0]       dbg_data,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [31:0]       ifid_inst,
    output logic              ifid_valid
);

    // Wide enough to hold DBG_MAX_WAIT itself (the saturation value).
    localparam int unsigned       CNT_W    = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(DBG_MAX_WAIT);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    // ACK lasts exactly one cycle after a debug grant.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_ACK   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   ifid_pc_q;
    logic [31:0]         ifid_inst_q;
    logic                ifid_valid_q;
    logic [31:0]         dbg_data_q;
    logic [CNT_W-1:0]    wait_cnt_q;

    logic                grant_d;
    logic [ADDR_W-1:0]   pc_inc_d;

    // Debug owns the ROM port this cycle when the pipeline is frozen anyway
    // (free slot) or the requester has been starved long enough. A branch
    // always keeps the port so the redirect is never lost.
    always_comb begin
        grant_d = (state_q == ST_FETCH) && dbg_req && !br_taken
                  && (freeze || (wait_cnt_q == WAIT_MAX));
    end

    // Sequential successor of the PC; wraps modulo 2^ADDR_W with no flag.
    assign pc_inc_d  = pc_q + STEP;

    assign imem_adrs = grant_d ? dbg_adrs : pc_q;

    assign dbg_ack    = (state_q == ST_ACK);
    assign dbg_data   = dbg_data_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_valid = ifid_valid_q;

    // PC, IF/ID register, debug FSM and starvation counter, all updated together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= '0;
            ifid_valid_q <= 1'b0;
            dbg_data_q   <= '0;
            wait_cnt_q   <= '0;
        end else begin
            // FSM: a grant moves to ACK; ACK always returns to FETCH and
            // never re-grants the still-held request.
            state_q <= grant_d ? ST_ACK : ST_FETCH;

            // Starvation counter only advances on cycles the fetch stream
            // actually used the port instead of the debug requester.
            if (grant_d || !dbg_req) begin
                wait_cnt_q <= '0;
            end else if (!freeze && (wait_cnt_q != WAIT_MAX)) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end

            // Fetch path, priority: branch, debug grant, freeze, sequential.
            if (br_taken) begin
                pc_q         <= br_addr;
                ifid_valid_q <= 1'b0;
            end else if (grant_d) begin
                dbg_data_q <= imem_inst;
                // An unfrozen pipeline lost its fetch slot: insert a bubble.
                if (!freeze) begin
                    ifid_valid_q <= 1'b0;
                end
            end else if (!freeze) begin
                ifid_inst_q  <= imem_inst;
                ifid_pc_q    <= pc_inc_d;
                ifid_valid_q <= 1'b1;
                pc_q         <= pc_inc_d;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The driver applies one vector per clock,
// checks the combinational ROM address, and queues the hand-computed IF/ID and
// debug results; a negedge monitor pops and compares them as the DUT shows them.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_adrs;
    logic [31:0] imem_inst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        dbg_req;
    logic [31:0] dbg_adrs;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;

    int tests = 0;
    int fails = 0;
    int vec_n = 0;

    typedef struct {
        int          idx;
        logic        v;
        logic        chk;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ack;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] dbg_q[$];

    // ROM contents: distinct, easy to recognise words.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_inst = rom(imem_adrs);

    fetch_sequencer #(
        .ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .DBG_MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_adrs(imem_adrs), .imem_inst(imem_inst),
        .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
        .dbg_req(dbg_req), .dbg_adrs(dbg_adrs),
        .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs for this cycle, expected imem_adrs during it,
    // expected IF/ID after the edge, and whether a debug ack must follow.
    task automatic vec(input logic r, input logic f, input logic b, input logic [31:0] ba,
                       input logic dq, input logic [31:0] da,
                       input logic ca, input logic [31:0] ea,
                       input logic ev, input logic ci, input logic [31:0] ep, input logic [31:0] ei,
                       input logic eg, input logic [31:0] ed);
        exp_t e;
        rst_n    = r;
        freeze   = f;
        br_taken = b;
        br_addr  = ba;
        dbg_req  = dq;
        dbg_adrs = da;
        #1;
        if (ca) begin
            tests++;
            if (imem_adrs !== ea) begin
                fails++;
                $display("FAIL imem_adrs vec%0d: got %h expected %h", vec_n, imem_adrs, ea);
            end
        end
        e.idx  = vec_n;
        e.v    = ev;
        e.chk  = ci;
        e.pc   = ep;
        e.inst = ei;
        e.ack  = eg;
        exp_q.push_back(e);
        if (eg) dbg_q.push_back(ed);
        vec_n++;
        @(posedge clk);
        #1;
    endtask

    // Plain sequential fetch from address a.
    task automatic run(input logic [31:0] a, input logic dq, input logic [31:0] da);
        vec(1, 0, 0, 32'h0, dq, da, 1, a, 1, 1, a + 32'd4, rom(a), 0, 32'h0);
    endtask

    // Monitor: compares the queued expectation against the DUT every cycle and
    // checks debug data whenever the DUT raises dbg_ack.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (ifid_valid !== e.v) begin
                fails++;
                $display("FAIL ifid_valid vec%0d: got %b expected %b", e.idx, ifid_valid, e.v);
            end
            if (e.chk) begin
                tests++;
                if (ifid_pc !== e.pc) begin
                    fails++;
                    $display("FAIL ifid_pc vec%0d: got %h expected %h", e.idx, ifid_pc, e.pc);
                end
                tests++;
                if (ifid_inst !== e.inst) begin
                    fails++;
                    $display("FAIL ifid_inst vec%0d: got %h expected %h", e.idx, ifid_inst, e.inst);
                end
            end
            tests++;
            if (dbg_ack !== e.ack) begin
                fails++;
                $display("FAIL dbg_ack vec%0d: got %b expected %b", e.idx, dbg_ack, e.ack);
            end
            $display("[TB] vec%0d ifid v=%b pc=%h inst=%h ack=%b", e.idx, ifid_valid, ifid_pc, ifid_inst, dbg_ack);
        end
        if (dbg_ack === 1'b1) begin
            tests++;
            if (dbg_q.size() == 0) begin
                fails++;
                $display("FAIL dbg_unexpected: got ack with data %h, expected no ack", dbg_data);
            end else begin
                d = dbg_q.pop_front();
                if (dbg_data !== d) begin
                    fails++;
                    $display("FAIL dbg_data: got %h expected %h", dbg_data, d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_addr = '0;
        dbg_req = 1'b0; dbg_adrs = '0;

        // Reset: IF/ID cleared
        vec(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 32'h0, 0, 32'h0);
        // T1: free run 0..20
        for (int a = 0; a <= 20; a += 4) run(32'(a), 0, 32'h0);
        // Redirect to 4, then one fetch so pc=8
        vec(1, 0, 1, 32'h4, 0, 32'h0, 1, 32'd24, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        run(32'd4, 0, 32'h0);
        // T2: freeze three cycles at pc=8, IF/ID held
        for (int i = 0; i < 3; i++)
            vec(1, 1, 0, 32'h0, 0, 32'h0, 1, 32'd8, 1, 1, 32'd8, rom(32'd4), 0, 32'h0);
        run(32'd8, 0, 32'h0);
        run(32'd12, 0, 32'h0);
        // T3: branch with freeze -> bubble, next fetch at 0x40
        vec(1, 1, 1, 32'h40, 0, 32'h0, 1, 32'd16, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        run(32'h40, 0, 32'h0);
        // T4: debug read during freeze, IF/ID held, ack next cycle, pc unchanged
        vec(1, 1, 0, 32'h0, 1, 32'd16, 1, 32'd16, 1, 1, 32'h44, rom(32'h40), 1, rom(32'd16));
        run(32'h44, 0, 32'h0);
        // T5: starved request granted on 5th cycle with one bubble
        for (int a = 'h48; a <= 'h54; a += 4) run(32'(a), 1, 32'h100);
        vec(1, 0, 0, 32'h0, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0, 32'h0, 1, rom(32'h100));
        run(32'h58, 0, 32'h0);
        // Branch beats a grantable request; request granted the cycle after
        vec(1, 1, 1, 32'h80, 1, 32'h20, 1, 32'h5C, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        vec(1, 1, 0, 32'h0, 1, 32'h20, 1, 32'h20, 0, 0, 32'h0, 32'h0, 1, rom(32'h20));
        run(32'h80, 0, 32'h0);
        // T6: reset in a grant cycle -> no ack, restart at 0
        vec(0, 1, 0, 32'h0, 1, 32'h30, 1, 32'h30, 0, 1, 32'h0, 32'h0, 0, 32'h0);
        run(32'h0, 0, 32'h0);
        // PC wrap 0xFFFFFFFC -> 0
        vec(1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'd4, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        run(32'hFFFF_FFF8, 0, 32'h0);
        run(32'hFFFF_FFFC, 0, 32'h0);
        run(32'h0, 0, 32'h0);
        // Dropping the request clears the wait count
        run(32'd4, 1, 32'h200);
        run(32'd8, 1, 32'h200);
        run(32'd12, 0, 32'h0);
        for (int a = 16; a <= 28; a += 4) run(32'(a), 1, 32'h200);
        vec(1, 0, 0, 32'h0, 1, 32'h200, 1, 32'h200, 0, 0, 32'h0, 32'h0, 1, rom(32'h200));
        run(32'd32, 0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL ifid_queue: got %0d unchecked entries, expected 0", exp_q.size());
        end
        tests++;
        if (dbg_q.size() != 0) begin
            fails++;
            $display("FAIL dbg_queue: got %0d missing acks, expected 0", dbg_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net: the run is bounded even if the DUT misbehaves badly.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
